// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg
//   Shared definitions for the multi-precision CLA sequencer.
//   SLICE_W       : width of one adder slice (the CLA_16bit datapath width)
//   mpadd_state_t : sequencer FSM state encoding
package cla_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mpadd_state_t;

endpackage

// File: rtl/CLA_16bit.sv
// CLA_16bit
//   16-bit carry-lookahead adder built from four 4-bit lookahead groups with a
//   second lookahead level across the groups. Purely combinational.
//   A, B : 16-bit addends
//   cin  : carry into bit 0
//   out  : 16-bit sum
//   cout : carry out of bit 15
module CLA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        cin,
  output logic        cout,
  output logic [15:0] out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [3:0]  gc;

  assign g = A & B;
  assign p = A ^ B;

  // Group generate/propagate for each 4-bit group.
  always_comb begin
    gg = '0;
    pg = '0;
    for (int grp = 0; grp < 4; grp++) begin
      gg[grp] = g[4*grp+3]
              | (p[4*grp+3] & g[4*grp+2])
              | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
              | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]);
      pg[grp] = &p[4*grp +: 4];
    end
  end

  // Second-level lookahead: carries into each group, computed in parallel.
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (pg[0] & cin);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & cin);
    cout  = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
  end

  // Bit carries inside each group, seeded from the group carry-in.
  always_comb begin
    c = '0;
    for (int grp = 0; grp < 4; grp++) begin
      c[4*grp]   = gc[grp];
      c[4*grp+1] = g[4*grp]   | (p[4*grp]   & gc[grp]);
      c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                 | (p[4*grp+1] & p[4*grp] & gc[grp]);
      c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                 | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                 | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & gc[grp]);
    end
  end

  assign out = p ^ c;

endmodule

// File: rtl/cla_mpadd_seq.sv
// cla_mpadd_seq
//   Multi-precision add/subtract sequencer. Wide operands are pushed through a
//   single CLA_16bit one slice per cycle, least-significant slice first, with
//   the inter-slice carry held in a register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   dbg_state           : current FSM state, for observation only
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid && ready are both 1. in_ready is 1 only in IDLE and out_valid is
// 1 only in DONE; both are decoded from the state register, so neither depends
// combinationally on any input. Once out_valid is high, sum/cout/ovf hold
// until the transfer edge. in_valid outside IDLE is ignored.
module cla_mpadd_seq
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] sum,
  output logic                     cout,
  output logic                     ovf,
  output mpadd_state_t             dbg_state
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  mpadd_state_t     state;
  mpadd_state_t     state_nx;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     sum_r;
  logic             carry_r;
  logic             ovf_r;

  logic [SLICE_W-1:0] cla_a;
  logic [SLICE_W-1:0] cla_b;
  logic [SLICE_W-1:0] cla_out;
  logic               cla_cout;
  logic               last_slice;

  // Slice mux feeding the shared adder.
  assign cla_a      = a_r[idx*SLICE_W +: SLICE_W];
  assign cla_b      = b_r[idx*SLICE_W +: SLICE_W];
  assign last_slice = (idx == LAST_IDX);

  CLA_16bit u_cla (
    .A    (cla_a),
    .B    (cla_b),
    .cin  (carry_r),
    .cout (cla_cout),
    .out  (cla_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)   state_nx = RUN;
      RUN:     if (last_slice) state_nx = DONE;
      DONE:    if (out_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath. Subtraction is a + ~b + ~cin, so b and the borrow are inverted
  // once at capture and the slice loop is identical for add and subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? ~cin : cin;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_r[idx*SLICE_W +: SLICE_W] <= cla_out;
          carry_r <= cla_cout;
          if (last_slice) begin
            idx   <= '0;
            // Signed overflow: operands share a sign that the result lacks.
            ovf_r <= (a_r[W-1] == b_r[W-1]) && (cla_out[SLICE_W-1] != a_r[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = carry_r;
  assign ovf       = ovf_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_cla_mpadd_seq.sv
module tb_cla_mpadd_seq;
  import cla_seq_pkg::*;

  localparam int WORDS = 4;
  localparam int W     = SLICE_W * WORDS;
  localparam int RW    = W + 2;   // {ovf, cout, sum}

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  mpadd_state_t dbg_state;

  int n_tests;
  int n_fail;

  logic [RW-1:0] exp_q[$];

  cla_mpadd_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned for sum/carry, sign-extended for overflow.
  function automatic logic [RW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic cv, input logic sv);
    logic [W:0]   ur;
    logic [W+1:0] sr;
    logic [W+1:0] sa;
    logic [W+1:0] sb;
    logic         c_o;
    logic         v_o;
    sa = {{2{av[W-1]}}, av};
    sb = {{2{bv[W-1]}}, bv};
    if (!sv) begin
      ur  = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      sr  = sa + sb + {{(W+1){1'b0}}, cv};
      c_o = ur[W];
    end else begin
      ur  = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv};
      sr  = sa - sb - {{(W+1){1'b0}}, cv};
      c_o = ~ur[W];   // 1 means no borrow
    end
    v_o = !((sr[W+1] == sr[W]) && (sr[W] == sr[W-1]));
    return {v_o, c_o, ur[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_in_ready();
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", {{(RW-1){1'b0}}, in_ready}, {{(RW-1){1'b0}}, 1'b1});
  endtask

  // Issue one operation, check latency, hold out_ready low for 'hold' cycles
  // while pulsing in_valid with junk, then complete the output handshake.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic sv, input int hold, input string tag);
    int            lat;
    logic [RW-1:0] first;
    logic [RW-1:0] exp;
    wait_in_ready();
    a        = av;
    b        = bv;
    cin      = cv;
    sub      = sv;
    in_valid = 1'b1;
    exp_q.push_back(model(av, bv, cv, sv));
    @(negedge clk);
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    check({tag, "_in_ready_busy"}, {{(RW-1){1'b0}}, in_ready}, '0);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      if (!out_valid) lat++;
    end
    // out_valid is seen on the negedge after edge E(WORDS)
    check({tag, "_latency"}, RW'(lat), RW'(WORDS));
    first = {ovf, cout, sum};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      cin      = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, "_hold_stable"}, {ovf, cout, sum}, first);
      check({tag, "_hold_flags"}, {{(RW-2){1'b0}}, out_valid, in_ready}, RW'(2'b10));
    end
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_result"}, {ovf, cout, sum}, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_after_hs"}, {{(RW-2){1'b0}}, out_valid, in_ready}, RW'(2'b01));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_tests = 0;
    n_fail  = 0;

    repeat (2) @(negedge clk);
    check("rst_flags", {{(RW-2){1'b0}}, out_valid, in_ready}, RW'(2'b01));
    check("rst_result", {ovf, cout, sum}, '0);
    check("rst_state", RW'(dbg_state), RW'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, "slice_carry");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, "full_chain");
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, "pos_ovf");
    do_op(64'h5, 64'h7, 1'b0, 1'b1, 0, "sub_neg");
    do_op(64'h7, 64'h5, 1'b1, 1'b1, 0, "sub_borrow_in");
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 0, "neg_ovf");
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 3, "backpressure");

    // Reset during RUN after two slices have been written
    wait_in_ready();
    a        = 64'hFFFF_FFFF_FFFF_FFFF;
    b        = 64'h1;
    cin      = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {{(RW-2){1'b0}}, out_valid, in_ready}, RW'(2'b01));
    check("midrst_sum", {ovf, cout, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", RW'(dbg_state), RW'(IDLE));
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, "post_rst");

    // Randomized operations, with occasional corner operands
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = '0;
        2: ra = {1'b0, {(W-1){1'b1}}};
        3: rb = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
